// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//   Execute-stage ALU. Takes a 3-bit ALU control code and two operands, and
//   returns a registered result with a zero flag. Most operations finish in
//   one cycle. SLL with a non-zero shift amount runs on an iterative shifter
//   that moves one bit per cycle. Valid/ready handshakes on the input and
//   output sides let the pipeline stall while a shift is running or while
//   the consumer is not ready.
//
// Parameters
//   WIDTH     operand/result width
//   SHW       shift-amount width (clog2(WIDTH))
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous reset, active-low
//   in_valid   operation presented
//   in_ready   unit accepts the operation this cycle
//   ALUin      NOP=000 ADD=001 SUB=010 AND=011 OR=100 XOR=101 SLT=110 SLL=111
//   op_a       operand A (rs)
//   op_b       operand B (rt/immediate); SLL source
//   shamt      shift amount, SLL only
//   out_valid  result/zero valid
//   out_ready  consumer takes the result this cycle
//   result     operation result
//   zero       result == 0
// ---------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALUin,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    // state   | meaning
    // S_IDLE  | ready for a new op; output register may hold a pending result
    // S_SHIFT | iterative SLL in progress, input side stalled
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_SLL = 3'b111;

    state_t           state_q;
    logic [WIDTH-1:0] sreg_q;
    logic [SHW-1:0]   cnt_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             out_valid_q;

    logic [WIDTH-1:0] alu_d;
    logic [WIDTH-1:0] sreg_shl_d;
    logic             slt_d;
    logic             accept;
    logic             multi_cycle;

    // The input side may move whenever the output register is empty or is
    // being drained on this same edge. This is what allows one op per cycle.
    assign in_ready    = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept      = in_valid && in_ready;
    assign multi_cycle = (ALUin == OP_SLL) && (shamt != '0);

    assign slt_d      = $signed(op_a) < $signed(op_b);
    assign sreg_shl_d = sreg_q << 1;

    // Single-cycle datapath. SLL lands here only when shamt is 0, where the
    // result is op_b unchanged.
    always_comb begin
        alu_d = '0;
        case (ALUin)
            OP_NOP:  alu_d = '0;
            OP_ADD:  alu_d = op_a + op_b;
            OP_SUB:  alu_d = op_a - op_b;
            OP_AND:  alu_d = op_a & op_b;
            OP_OR:   alu_d = op_a | op_b;
            OP_XOR:  alu_d = op_a ^ op_b;
            OP_SLT:  alu_d = {{(WIDTH-1){1'b0}}, slt_d};
            OP_SLL:  alu_d = op_b;
            default: alu_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sreg_q      <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (multi_cycle) begin
                            sreg_q      <= op_b;
                            cnt_q       <= shamt;
                            out_valid_q <= 1'b0;
                            state_q     <= S_SHIFT;
                        end else begin
                            result_q    <= alu_d;
                            zero_q      <= (alu_d == '0);
                            out_valid_q <= 1'b1;
                        end
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end

                S_SHIFT: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == {{(SHW-1){1'b0}}, 1'b1}) begin
                        // The final shift goes straight into the output
                        // register, so the latency equals shamt.
                        result_q    <= sreg_shl_d;
                        zero_q      <= (sreg_shl_d == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        sreg_q <= sreg_shl_d;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;

endmodule
